// File: rtl/fuel_station_ctrl.sv
`timescale 1ns/1ps
// Two-fuel station controller: per-type FIFO queues of pending amounts, dispatch to
// idle pumps, one unit per busy pump per RUN cycle, with SETUP/ENTRY/HOLD modes.
module fuel_station_ctrl #(
    parameter int N_PUMPS     = 6,
    parameter int QUEUE_DEPTH = 8,
    parameter int MAX_FUEL    = 8,
    parameter int FUEL_W      = 4,
    parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1),
    parameter int TOT_W       = 8,
    parameter int PN_W        = $clog2(N_PUMPS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         mode,
    input  logic [PN_W-1:0]    n_gasoline_pumps,
    input  logic [PN_W-1:0]    n_diesel_pumps,
    input  logic [FUEL_W-1:0]  fuel_amount,
    input  logic               fuel_type,
    output logic [N_PUMPS-1:0] pump_status,
    output logic [N_PUMPS-1:0] pump_busy,
    output logic               is_gasoline_queue_not_full,
    output logic               is_diesel_queue_not_full,
    output logic [CNT_W-1:0]   n_cars_in_gasoline_queue,
    output logic [CNT_W-1:0]   n_cars_in_diesel_queue,
    output logic [TOT_W-1:0]   total_gasoline_needed,
    output logic [TOT_W-1:0]   total_diesel_needed,
    output logic               invalid_gasoline_car,
    output logic               invalid_diesel_car,
    output logic               invalid_setup_params,
    output logic [7:0]         served_count
);
    localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int SW = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1;

    typedef enum logic [1:0] {M_RUN = 2'b00, M_ENTRY = 2'b01, M_SETUP = 2'b10, M_HOLD = 2'b11} mode_e;
    typedef enum logic {S_UNCONF = 1'b0, S_CONF = 1'b1} state_e;

    state_e                       state_q, state_d;
    logic [PN_W-1:0]              ng_q, ng_d, nd_q, nd_d;
    logic [N_PUMPS-1:0]           busy_q, busy_d;
    logic [FUEL_W-1:0]            rem_q [N_PUMPS];
    logic [FUEL_W-1:0]            rem_d [N_PUMPS];
    logic [FUEL_W-1:0]            qmem_q [2][QUEUE_DEPTH];
    logic [FUEL_W-1:0]            qmem_d [2][QUEUE_DEPTH];
    logic [1:0][QW-1:0]           qhead_q, qhead_d;
    logic [1:0][CNT_W-1:0]        qcnt_q, qcnt_d;
    logic [7:0]                   served_q, served_d;
    logic [N_PUMPS-1:0]           status_q, status_d;
    logic                         inv_g_q, inv_g_d, inv_d_q, inv_d_d, inv_s_q, inv_s_d;
    logic [1:0]                   nf_q, nf_d;
    logic [1:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0][TOT_W-1:0]        tot_q, tot_d;

    int   setup_sum;
    logic setup_ok;
    assign setup_sum = int'(n_gasoline_pumps) + int'(n_diesel_pumps);
    assign setup_ok  = (setup_sum >= 1) && (setup_sum <= N_PUMPS);

    // Gasoline owns pumps [0, g); diesel owns [g, g+d).
    function automatic logic pump_is(input int k, input logic t,
                                     input logic [PN_W-1:0] g, input logic [PN_W-1:0] d);
        int lo, hi;
        lo = t ? int'(g) : 0;
        hi = t ? int'(g) + int'(d) : int'(g);
        return (k >= lo) && (k < hi);
    endfunction

    always_comb begin
        logic          t;
        logic          en;
        logic          found;
        logic [SW-1:0] slot;
        logic [QW-1:0] tail;
        int            taken [2];
        state_d  = state_q;
        ng_d     = ng_q;
        nd_d     = nd_q;
        busy_d   = busy_q;
        rem_d    = rem_q;
        qmem_d   = qmem_q;
        qhead_d  = qhead_q;
        qcnt_d   = qcnt_q;
        served_d = served_q;
        status_d = '0;
        inv_g_d  = 1'b0;
        inv_d_d  = 1'b0;
        inv_s_d  = inv_s_q;
        t        = fuel_type;
        en       = 1'b0;
        found    = 1'b0;
        slot     = '0;
        tail     = '0;
        taken[0] = 0;
        taken[1] = 0;
        case (mode_e'(mode))
            M_SETUP: begin
                busy_d   = '0;
                qhead_d  = '0;
                qcnt_d   = '0;
                served_d = '0;
                if (setup_ok) begin
                    state_d = S_CONF;
                    ng_d    = n_gasoline_pumps;
                    nd_d    = n_diesel_pumps;
                    inv_s_d = 1'b0;
                end else begin
                    state_d = S_UNCONF;
                    inv_s_d = 1'b1;
                end
            end
            M_ENTRY: begin
                if (state_q == S_CONF) begin
                    for (int k = 0; k < N_PUMPS; k++) begin
                        if (!found && !busy_q[k] && pump_is(k, t, ng_q, nd_q)) begin
                            found = 1'b1;
                            slot  = SW'(k);
                        end
                    end
                    en   = t ? (nd_q != '0) : (ng_q != '0);
                    tail = QW'((int'(qhead_q[t]) + int'(qcnt_q[t])) % QUEUE_DEPTH);
                    if (!en || fuel_amount == '0 || fuel_amount > FUEL_W'(MAX_FUEL) ||
                        (!found && int'(qcnt_q[t]) >= QUEUE_DEPTH)) begin
                        if (t) inv_d_d = 1'b1;
                        else   inv_g_d = 1'b1;
                    end else if (found) begin
                        busy_d[slot] = 1'b1;
                        rem_d[slot]  = fuel_amount;
                    end else begin
                        qmem_d[t][tail] = fuel_amount;
                        qcnt_d[t]       = qcnt_q[t] + CNT_W'(1);
                    end
                end
            end
            M_RUN: begin
                if (state_q == S_CONF) begin
                    // Idle pumps take successive queue entries in index order.
                    for (int k = 0; k < N_PUMPS; k++) begin
                        t = pump_is(k, 1'b1, ng_q, nd_q);
                        if (t || pump_is(k, 1'b0, ng_q, nd_q)) begin
                            if (busy_q[k]) begin
                                rem_d[k] = rem_q[k] - FUEL_W'(1);
                                if (rem_q[k] == FUEL_W'(1)) begin
                                    busy_d[k]               = 1'b0;
                                    status_d[N_PUMPS-1-k]   = 1'b1;
                                    served_d                = served_d + 8'd1;
                                end
                            end else if (taken[t] < int'(qcnt_q[t])) begin
                                busy_d[k] = 1'b1;
                                rem_d[k]  = qmem_q[t][QW'((int'(qhead_q[t]) + taken[t]) % QUEUE_DEPTH)];
                                taken[t]  = taken[t] + 1;
                            end
                        end
                    end
                    for (int ty = 0; ty < 2; ty++) begin
                        qhead_d[ty] = QW'((int'(qhead_q[ty]) + taken[ty]) % QUEUE_DEPTH);
                        qcnt_d[ty]  = qcnt_q[ty] - CNT_W'(taken[ty]);
                    end
                end
            end
            default: ;
        endcase
    end

    // Status outputs are computed from next state so they land in flops with the state.
    always_comb begin
        int   acc;
        logic en;
        logic idle;
        acc  = 0;
        en   = 1'b0;
        idle = 1'b0;
        nf_d  = '0;
        cnt_d = '0;
        tot_d = '0;
        for (int ty = 0; ty < 2; ty++) begin
            acc  = 0;
            idle = 1'b0;
            en   = (state_d == S_CONF) && ((ty == 1) ? (nd_d != '0) : (ng_d != '0));
            for (int k = 0; k < N_PUMPS; k++) begin
                if (pump_is(k, 1'(ty), ng_d, nd_d)) begin
                    if (busy_d[k]) acc = acc + int'(rem_d[k]);
                    else           idle = 1'b1;
                end
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (i < int'(qcnt_d[ty]))
                    acc = acc + int'(qmem_d[ty][QW'((int'(qhead_d[ty]) + i) % QUEUE_DEPTH)]);
            end
            cnt_d[ty] = en ? qcnt_d[ty] : '1;
            tot_d[ty] = en ? TOT_W'(acc) : '1;
            nf_d[ty]  = en && ((int'(qcnt_d[ty]) < QUEUE_DEPTH) || idle);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_UNCONF;
            ng_q     <= '0;
            nd_q     <= '0;
            busy_q   <= '0;
            qhead_q  <= '0;
            qcnt_q   <= '0;
            served_q <= '0;
            status_q <= '0;
            inv_g_q  <= 1'b0;
            inv_d_q  <= 1'b0;
            inv_s_q  <= 1'b0;
            nf_q     <= '0;
            cnt_q    <= '1;
            tot_q    <= '1;
        end else begin
            state_q  <= state_d;
            ng_q     <= ng_d;
            nd_q     <= nd_d;
            busy_q   <= busy_d;
            qhead_q  <= qhead_d;
            qcnt_q   <= qcnt_d;
            served_q <= served_d;
            status_q <= status_d;
            inv_g_q  <= inv_g_d;
            inv_d_q  <= inv_d_d;
            inv_s_q  <= inv_s_d;
            nf_q     <= nf_d;
            cnt_q    <= cnt_d;
            tot_q    <= tot_d;
        end
    end

    // Amount storage is only meaningful under busy/count, so it needs no reset.
    always_ff @(posedge CLK) begin
        rem_q  <= rem_d;
        qmem_q <= qmem_d;
    end

    always_comb begin
        pump_busy = '0;
        for (int k = 0; k < N_PUMPS; k++) pump_busy[N_PUMPS-1-k] = busy_q[k];
    end

    assign pump_status                = status_q;
    assign is_gasoline_queue_not_full = nf_q[0];
    assign is_diesel_queue_not_full   = nf_q[1];
    assign n_cars_in_gasoline_queue   = cnt_q[0];
    assign n_cars_in_diesel_queue     = cnt_q[1];
    assign total_gasoline_needed      = tot_q[0];
    assign total_diesel_needed        = tot_q[1];
    assign invalid_gasoline_car       = inv_g_q;
    assign invalid_diesel_car         = inv_d_q;
    assign invalid_setup_params       = inv_s_q;
    assign served_count               = served_q;
endmodule

// File: tb/tb_fuel_station_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for fuel_station_ctrl: each stimulus cycle queues its expected outputs
// (-1 = don't care); a monitor pops and compares them one cycle later on the falling edge.
module tb_fuel_station_ctrl;
    localparam int F_ST = 0, F_BZ = 1, F_GC = 2, F_GT = 3, F_GNF = 4, F_DC = 5;
    localparam int F_DT = 6, F_DNF = 7, F_IG = 8, F_ID = 9, F_IS = 10, F_SV = 11;
    localparam logic [1:0] RUN = 2'b00, ENTRY = 2'b01, SETUP = 2'b10, HOLD = 2'b11;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] mode = RUN;
    logic [2:0] ng = '0, nd = '0;
    logic [3:0] amt = '0;
    logic       ty = 1'b0;
    logic [5:0] pump_status, pump_busy;
    logic       gnf, dnf, ig, id, is_;
    logic [3:0] gc, dc;
    logic [7:0] gt, dt, served;

    fuel_station_ctrl dut (
        .CLK(CLK), .RST(RST), .mode(mode),
        .n_gasoline_pumps(ng), .n_diesel_pumps(nd),
        .fuel_amount(amt), .fuel_type(ty),
        .pump_status(pump_status), .pump_busy(pump_busy),
        .is_gasoline_queue_not_full(gnf), .is_diesel_queue_not_full(dnf),
        .n_cars_in_gasoline_queue(gc), .n_cars_in_diesel_queue(dc),
        .total_gasoline_needed(gt), .total_diesel_needed(dt),
        .invalid_gasoline_car(ig), .invalid_diesel_car(id),
        .invalid_setup_params(is_), .served_count(served)
    );

    always #5 CLK = ~CLK;

    int expq[$];
    int e[12];
    int n_chk = 0;
    int n_pass = 0;

    function automatic string fname(input int i);
        case (i)
            F_ST:    return "pump_status";
            F_BZ:    return "pump_busy";
            F_GC:    return "gas_count";
            F_GT:    return "gas_total";
            F_GNF:   return "gas_not_full";
            F_DC:    return "diesel_count";
            F_DT:    return "diesel_total";
            F_DNF:   return "diesel_not_full";
            F_IG:    return "invalid_gas";
            F_ID:    return "invalid_diesel";
            F_IS:    return "invalid_setup";
            default: return "served_count";
        endcase
    endfunction

    task automatic x(input int i, input int v);
        e[i] = v;
    endtask

    task automatic rst_exp();
        x(F_ST, 0); x(F_BZ, 0); x(F_GC, 15); x(F_GT, 255); x(F_GNF, 0); x(F_DC, 15);
        x(F_DT, 255); x(F_DNF, 0); x(F_IG, 0); x(F_ID, 0); x(F_IS, 0); x(F_SV, 0);
    endtask

    task automatic go(input logic r, input logic [1:0] m, input int g, input int d,
                      input int a, input int t);
        @(negedge CLK);
        RST  = r;
        mode = m;
        ng   = 3'(g);
        nd   = 3'(d);
        amt  = 4'(a);
        ty   = 1'(t);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 12; i++) expq.push_back(e[i]);
        for (int i = 0; i < 12; i++) e[i] = -1;
    endtask

    task automatic setup(input int g, input int d); go(1'b0, SETUP, g, d, 0, 0); endtask
    task automatic entry(input int t, input int a); go(1'b0, ENTRY, 0, 0, a, t); endtask
    task automatic run();  go(1'b0, RUN, 0, 0, 0, 0); endtask
    task automatic hold(); go(1'b0, HOLD, 0, 0, 0, 0); endtask

    initial begin
        int act[12];
        int ex;
        forever begin
            @(negedge CLK);
            if (expq.size() >= 12) begin
                act[F_ST] = int'(pump_status); act[F_BZ] = int'(pump_busy);
                act[F_GC] = int'(gc);  act[F_GT] = int'(gt);  act[F_GNF] = int'(gnf);
                act[F_DC] = int'(dc);  act[F_DT] = int'(dt);  act[F_DNF] = int'(dnf);
                act[F_IG] = int'(ig);  act[F_ID] = int'(id);  act[F_IS]  = int'(is_);
                act[F_SV] = int'(served);
                for (int i = 0; i < 12; i++) begin
                    ex = expq.pop_front();
                    if (ex >= 0) begin
                        n_chk++;
                        if (act[i] == ex) n_pass++;
                        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", fname(i), act[i], ex, $time);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++) e[i] = -1;

        rst_exp(); go(1'b1, RUN, 0, 0, 0, 0);
        x(F_IS, 1); x(F_GC, 15); x(F_GT, 255); x(F_GNF, 0); x(F_DC, 15); x(F_DT, 255); x(F_DNF, 0);
        setup(4, 3);
        x(F_IS, 0); x(F_DC, 0); x(F_DT, 0); x(F_DNF, 1); x(F_GC, 15); x(F_GT, 255); x(F_GNF, 0);
        x(F_SV, 0); setup(0, 1);

        x(F_BZ, 32); x(F_DT, 6); x(F_DC, 0); entry(1, 6);
        x(F_IG, 1); x(F_ID, 0); x(F_DT, 6); entry(0, 3);
        x(F_IG, 0); x(F_DC, 1); x(F_DT, 7); entry(1, 1);
        x(F_DC, 2); x(F_DT, 10); entry(1, 3);

        for (int i = 0; i < 5; i++) begin
            x(F_DT, 9 - i); x(F_ST, 0); x(F_BZ, 32); x(F_DC, 2); run();
        end
        x(F_DT, 4); x(F_ST, 32); x(F_SV, 1); x(F_BZ, 0); x(F_DNF, 1); run();
        x(F_DC, 1); x(F_DT, 4); x(F_BZ, 32); x(F_ST, 0); run();
        x(F_ST, 32); x(F_DT, 3); x(F_SV, 2); x(F_DC, 1); run();
        x(F_DC, 0); x(F_DT, 3); x(F_BZ, 32); run();
        x(F_DT, 2); run();
        x(F_DT, 1); run();
        x(F_DT, 0); x(F_ST, 32); x(F_SV, 3); x(F_BZ, 0); run();

        // Fill the single diesel pump and all eight queue slots, with bad amounts in between.
        x(F_DC, 0); x(F_DT, 5); entry(1, 5);
        x(F_ID, 1); x(F_DT, 5); x(F_DC, 0); entry(1, 0);
        x(F_ID, 1); x(F_DT, 5); entry(1, 9);
        for (int k = 1; k <= 8; k++) begin
            x(F_ID, 0); x(F_DC, k); x(F_DT, 5 + k * (k + 1) / 2); x(F_DNF, (k < 8) ? 1 : 0);
            entry(1, k);
        end
        x(F_ID, 1); x(F_DC, 8); x(F_DT, 41); x(F_DNF, 0); entry(1, 2);

        x(F_DT, 40); x(F_DC, 8); x(F_DNF, 0); x(F_ST, 0); run();
        for (int i = 0; i < 3; i++) begin
            x(F_DT, 40); x(F_DC, 8); x(F_ST, 0); x(F_ID, 0); x(F_BZ, 32); x(F_SV, 3); hold();
        end
        x(F_DT, 39); x(F_DC, 8); run();
        rst_exp(); go(1'b1, RUN, 0, 0, 0, 0);

        // Two pumps per type: dispatch order, queue reload and simultaneous finishers.
        x(F_IS, 0); x(F_GC, 0); x(F_GT, 0); x(F_GNF, 1); x(F_DC, 0); x(F_DT, 0); x(F_DNF, 1);
        x(F_SV, 0); x(F_BZ, 0); setup(2, 2);
        x(F_BZ, 32); x(F_GT, 2); x(F_GC, 0); entry(0, 2);
        x(F_BZ, 48); x(F_GT, 5); x(F_GNF, 1); entry(0, 3);
        x(F_GC, 1); x(F_GT, 6); x(F_GNF, 1); entry(0, 1);
        x(F_BZ, 56); x(F_DT, 4); x(F_GC, 1); entry(1, 4);
        x(F_GT, 4); x(F_DT, 3); x(F_ST, 0); run();
        x(F_ST, 32); x(F_GT, 2); x(F_SV, 1); x(F_BZ, 24); x(F_DT, 2); run();
        x(F_GC, 0); x(F_ST, 16); x(F_GT, 1); x(F_BZ, 40); x(F_SV, 2); x(F_DT, 1); run();
        x(F_ST, 40); x(F_SV, 4); x(F_GT, 0); x(F_DT, 0); x(F_BZ, 0); run();

        repeat (2) @(negedge CLK);
        #1;
        if (expq.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fuel_station_ctrl.md
# fuel_station_ctrl

Parametrised fuel-station controller with configurable pump count, queue depth and maximum fuel request. It serves two fuel types (gasoline, diesel), each with its own FIFO queue of pending fuel amounts. It dispatches cars to idle pumps and dispenses one unit per pump per cycle. It adds synchronous reset, per-pump busy flags, a served-car counter and a HOLD mode.

## Interface
- N_PUMPS, 6, total physical pumps (1..16)
- QUEUE_DEPTH, 8, per-type queue capacity
- MAX_FUEL, 8, largest legal fuel request
- FUEL_W, 4, width of fuel_amount; must hold MAX_FUEL
- CNT_W, $clog2(QUEUE_DEPTH+1), queue-count width
- TOT_W, 8, total-demand width; must hold (N_PUMPS+QUEUE_DEPTH)*MAX_FUEL
- PN_W, $clog2(N_PUMPS+1), pump-count input width

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- mode  in  2  00 RUN, 01 ENTRY, 10 SETUP, 11 HOLD
- n_gasoline_pumps  in  PN_W  SETUP: gasoline pump count
- n_diesel_pumps  in  PN_W  SETUP: diesel pump count
- fuel_amount  in  FUEL_W  ENTRY: requested units
- fuel_type  in  1  ENTRY: 0 gasoline, 1 diesel
- pump_status  out  N_PUMPS  one-cycle finish pulse per pump
- pump_busy  out  N_PUMPS  pump holds a car
- is_gasoline_queue_not_full, is_diesel_queue_not_full  out  1 each
- n_cars_in_gasoline_queue, n_cars_in_diesel_queue  out  CNT_W each
- total_gasoline_needed, total_diesel_needed  out  TOT_W each
- invalid_gasoline_car, invalid_diesel_car, invalid_setup_params  out  1 each
- served_count  out  8  cars completed; wraps 255 to 0

## Operation
- States: UNCONFIGURED (after reset or invalid setup) and CONFIGURED. All outputs are registered.
- Pump index k drives bit N_PUMPS-1-k. Pumps 0..G-1 are gasoline; pumps G..G+D-1 are diesel; the rest are unused and always 0.
- A type is disabled when its pump count is 0 or the block is UNCONFIGURED. A disabled type reports not_full=0, count all-ones and total all-ones.
- SETUP:
  - Valid iff 1 ≤ G+D ≤ N_PUMPS.
  - Valid: enter CONFIGURED; clear queues, pumps, totals and served_count; set invalid_setup_params=0.
  - Invalid: enter UNCONFIGURED; set invalid_setup_params=1.
  - SETUP is allowed from any state; a re-setup discards all cars.
- ENTRY (CONFIGURED only):
  - A car is rejected if its type is disabled, amount=0, amount>MAX_FUEL, or the queue is full with no idle pump of that type.
  - On rejection, invalid flag of that type =1 for that cycle only; no state change.
  - An accepted car goes directly to the lowest-index idle pump of its type (busy=1, remaining=amount). Otherwise it is appended to that type's queue.
  - No dispensing occurs in ENTRY.
- RUN:
  - Each busy pump decrements remaining by 1.
  - A pump whose remaining goes 1→0 raises its pump_status bit, clears busy, and increments served_count. Multiple finishers in one cycle add their combined count.
  - A pump that is idle at the start of a cycle loads the queue head of its type; that cycle it does not dispense.
  - If several pumps of one type are idle, the lowest index takes the head, the next index the following entry, and so on, up to the queue count.
- HOLD: all state is frozen; pump_status and invalid flags read 0.
- total_*_needed = sum of remaining in the type's pumps + sum of queued amounts.
- not_full = (count < QUEUE_DEPTH), or an idle pump of that type exists.

## Timing
- Reset and UNCONFIGURED values:
  - pump_status=0, pump_busy=0, not_full=0
  - counts all-ones, totals all-ones
  - invalid flags 0, served_count=0
- RST has priority over mode; reset mid-RUN discards all cars at that edge.
- Outputs reflect the inputs sampled at the preceding edge (1-cycle latency).
- ENTRY accepts one car per cycle. pump_status and invalid flags are single-cycle pulses.
- A finished pump idles for one full cycle before reloading. Effective cost per queued car is amount+1 cycles.
- Queue pointers wrap modulo QUEUE_DEPTH.
- served_count wraps silently from 255 to 0.

## Test plan
- Reset, then SETUP G=4/D=3 -> invalid_setup_params=1; counts 15; totals 255; not_full 0.
- SETUP G=0/D=1 -> invalid_setup 0; diesel count 0, total 0, not_full 1; gasoline 15/255.
- ENTRY diesel 6 -> pump_busy=100000, total 6. Then gasoline 3 -> invalid_gasoline_car=1. Then diesel 1 and diesel 3 -> diesel count 2, total 10.
- Continue in RUN:
  - Totals go 9,8,7,6,5,4; at total 4, pump_status=100000 and served_count=1.
  - Next cycle: count 1, total 4.
  - Next: pump_status pulse again, total 3.
  - Then load (count 0), then 2, 1, 0 with a final pulse; served_count=3.
- Full queue, 1 diesel pump: 9 valid diesel cars fill the pump plus 8 queue entries; not_full=0. The 10th car -> invalid_diesel_car=1, count stays 8.
- HOLD mid-RUN freezes totals and counts for 3 cycles. RST mid-RUN -> all reset values at the next edge.
